// File: rtl/mem_port_arbiter_if.sv
// Bundles the requester-side and memory-side signals of the memory port arbiter.
// The arbiter connects through the slave modport; requesters and the memory model connect through master.
interface mem_port_arbiter_if #(
  parameter int addr_width = 64,
  parameter int data_width = 64,
  parameter int NUM_REQ    = 2
);
  logic [NUM_REQ-1:0]            req_read_i;
  logic [NUM_REQ-1:0]            req_write_i;
  logic [NUM_REQ*addr_width-1:0] req_addr_i;
  logic [NUM_REQ*data_width-1:0] req_wdata_i;
  logic [NUM_REQ-1:0]            req_resp_o;
  logic [data_width-1:0]         req_rdata_o;
  logic                          mem_read;
  logic                          mem_write;
  logic [addr_width-1:0]         mem_addr;
  logic [data_width-1:0]         mem_wdata;
  logic                          mem_resp;
  logic [data_width-1:0]         mem_rdata;
  logic [NUM_REQ-1:0]            grant_o;
  logic                          busy_o;

  modport slave (
    input  req_read_i, req_write_i, req_addr_i, req_wdata_i, mem_resp, mem_rdata,
    output req_resp_o, req_rdata_o, mem_read, mem_write, mem_addr, mem_wdata, grant_o, busy_o
  );

  modport master (
    output req_read_i, req_write_i, req_addr_i, req_wdata_i, mem_resp, mem_rdata,
    input  req_resp_o, req_rdata_o, mem_read, mem_write, mem_addr, mem_wdata, grant_o, busy_o
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between NUM_REQ requesters,
// one outstanding transaction at a time.
//
//   state  | meaning
//   S_IDLE | no transaction; pick the next valid requester after r_last
//   S_BUSY | command latched on mem_*; waiting for mem_resp
module mem_port_arbiter #(
  parameter int addr_width = 64,
  parameter int data_width = 64,
  parameter int NUM_REQ    = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  mem_port_arbiter_if.slave   bus
);

  localparam int IDXW = $clog2(NUM_REQ);
  localparam logic [IDXW:0] NREQ_W = (IDXW+1)'(NUM_REQ);

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t                r_state,     w_state_nxt;
  logic [IDXW-1:0]       r_last,      w_last_nxt;
  logic [NUM_REQ-1:0]    r_grant,     w_grant_nxt;
  logic                  r_mem_read,  w_rd_nxt;
  logic                  r_mem_write, w_wr_nxt;
  logic [addr_width-1:0] r_mem_addr,  w_addr_nxt;
  logic [data_width-1:0] r_mem_wdata, w_wdata_nxt;

  logic [NUM_REQ-1:0]    w_valid;
  logic                  w_found;
  logic [IDXW-1:0]       w_winner;
  logic [IDXW:0]         w_sum;
  logic [NUM_REQ-1:0]    w_win_onehot;
  logic [addr_width-1:0] w_win_addr;
  logic [data_width-1:0] w_win_wdata;

  assign w_valid = bus.req_read_i | bus.req_write_i;

  // Search last+1, last+2, ... wrapping modulo NUM_REQ; first valid index wins.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_sum    = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum = {1'b0, r_last} + (IDXW+1)'(k);
      if (w_sum >= NREQ_W) w_sum = w_sum - NREQ_W;
      if (!w_found && w_valid[w_sum[IDXW-1:0]]) begin
        w_found  = 1'b1;
        w_winner = w_sum[IDXW-1:0];
      end
    end
  end

  always_comb begin
    w_win_onehot = '0;
    w_win_addr   = '0;
    w_win_wdata  = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDXW'(i)) begin
        w_win_onehot[i] = 1'b1;
        w_win_addr      = bus.req_addr_i[i*addr_width +: addr_width];
        w_win_wdata     = bus.req_wdata_i[i*data_width +: data_width];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_last      <= IDXW'(NUM_REQ-1);
      r_grant     <= '0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_last      <= w_last_nxt;
      r_grant     <= w_grant_nxt;
      r_mem_read  <= w_rd_nxt;
      r_mem_write <= w_wr_nxt;
      r_mem_addr  <= w_addr_nxt;
      r_mem_wdata <= w_wdata_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_last_nxt  = r_last;
    w_grant_nxt = r_grant;
    w_rd_nxt    = r_mem_read;
    w_wr_nxt    = r_mem_write;
    w_addr_nxt  = r_mem_addr;
    w_wdata_nxt = r_mem_wdata;
    case (r_state)
      S_IDLE: begin
        if (w_found) begin
          w_state_nxt = S_BUSY;
          w_last_nxt  = w_winner;
          w_grant_nxt = w_win_onehot;
          // Write takes precedence when a requester raises both.
          w_wr_nxt    = bus.req_write_i[w_winner];
          w_rd_nxt    = bus.req_read_i[w_winner] & ~bus.req_write_i[w_winner];
          w_addr_nxt  = w_win_addr;
          w_wdata_nxt = w_win_wdata;
        end
      end
      S_BUSY: begin
        if (bus.mem_resp) begin
          w_state_nxt = S_IDLE;
          w_grant_nxt = '0;
          w_rd_nxt    = 1'b0;
          w_wr_nxt    = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign bus.req_resp_o  = (r_state == S_BUSY && bus.mem_resp) ? r_grant : '0;
  assign bus.req_rdata_o = bus.mem_rdata;
  assign bus.mem_read    = r_mem_read;
  assign bus.mem_write   = r_mem_write;
  assign bus.mem_addr    = r_mem_addr;
  assign bus.mem_wdata   = r_mem_wdata;
  assign bus.grant_o     = r_grant;
  assign bus.busy_o      = (r_state == S_BUSY);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a 2-requester instance for single/contention/reset
// cases and a 4-requester instance for round-robin rotation.
module tb_mem_port_arbiter;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter_if #(.addr_width(64), .data_width(64), .NUM_REQ(2)) a ();
  mem_port_arbiter_if #(.addr_width(64), .data_width(64), .NUM_REQ(4)) b ();

  mem_port_arbiter #(.addr_width(64), .data_width(64), .NUM_REQ(2)) u_arb2 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (a)
  );

  mem_port_arbiter #(.addr_width(64), .data_width(64), .NUM_REQ(4)) u_arb4 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (b)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; raises the request, answers after lat command cycles, then drops it.
  task automatic txn_a(input int who, input bit rd, input bit wr,
                       input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [63:0] rdata, input int lat,
                       input logic [1:0] exp_grant, input bit exp_rd, input bit exp_wr);
    int ncmd;
    ncmd = 0;
    a.req_read_i[who]             = rd;
    a.req_write_i[who]            = wr;
    a.req_addr_i[who*64 +: 64]    = addr;
    a.req_wdata_i[who*64 +: 64]   = wdata;
    for (int c = 1; c <= lat; c++) begin
      @(negedge clk);
      if (a.mem_read | a.mem_write) ncmd++;
      if (c == 1) begin
        chk("grant",     64'(a.grant_o),   64'(exp_grant));
        chk("busy",      64'(a.busy_o),    64'd1);
        chk("mem_read",  64'(a.mem_read),  64'(exp_rd));
        chk("mem_write", 64'(a.mem_write), 64'(exp_wr));
        chk("mem_addr",  a.mem_addr,       addr);
        if (exp_wr) chk("mem_wdata", a.mem_wdata, wdata);
      end else begin
        chk("resp_wait", 64'(a.req_resp_o), 64'd0);
      end
      if (c == lat) begin
        a.mem_resp  = 1'b1;
        a.mem_rdata = rdata;
        #1;
        chk("resp",  64'(a.req_resp_o), 64'(exp_grant));
        chk("rdata", a.req_rdata_o,     rdata);
      end
    end
    @(negedge clk);
    a.mem_resp         = 1'b0;
    a.req_read_i[who]  = 1'b0;
    a.req_write_i[who] = 1'b0;
    chk("cmd_cycles", 64'(ncmd), 64'(lat));
    chk("post_cmd",   64'({a.mem_read, a.mem_write, a.busy_o}), 64'd0);
    chk("post_grant", 64'(a.grant_o), 64'd0);
    chk("addr_held",  a.mem_addr, addr);
  endtask

  initial begin
    logic [3:0] exp_g;
    a.req_read_i = '0; a.req_write_i = '0; a.req_addr_i = '0; a.req_wdata_i = '0;
    a.mem_resp = 1'b0; a.mem_rdata = '0;
    b.req_read_i = '0; b.req_write_i = '0; b.req_addr_i = '0; b.req_wdata_i = '0;
    b.mem_resp = 1'b0; b.mem_rdata = '0;

    // reset, then quiet idle
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outs", 64'({a.mem_read, a.mem_write, a.busy_o, a.grant_o}), 64'd0);
    chk("rst_addr", a.mem_addr, 64'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_outs", 64'({a.mem_read, a.mem_write, a.busy_o, a.grant_o, a.req_resp_o}), 64'd0);
    end
    a.mem_resp = 1'b1;
    #1;
    chk("idle_resp", 64'(a.req_resp_o), 64'd0);
    @(negedge clk);
    a.mem_resp = 1'b0;
    chk("idle_busy", 64'({a.busy_o, a.grant_o}), 64'd0);

    // contention straight after reset: req0 first, then req1
    a.req_read_i = 2'b11;
    a.req_addr_i[0 +: 64]  = 64'h100;
    a.req_addr_i[64 +: 64] = 64'h200;
    txn_a(0, 1'b1, 1'b0, 64'h100, 64'h0, 64'hAAAA, 1, 2'b01, 1'b1, 1'b0);
    txn_a(1, 1'b1, 1'b0, 64'h200, 64'h0, 64'hBBBB, 1, 2'b10, 1'b1, 1'b0);

    // single write, 3-cycle memory
    txn_a(1, 1'b0, 1'b1, 64'h40, 64'hDEAD, 64'h0, 3, 2'b10, 1'b0, 1'b1);
    // single read
    txn_a(0, 1'b1, 1'b0, 64'h80, 64'h0, 64'h1234, 2, 2'b01, 1'b1, 1'b0);
    // read and write together: write wins
    txn_a(0, 1'b1, 1'b1, 64'h90, 64'h77, 64'h0, 1, 2'b01, 1'b0, 1'b1);

    // round robin on the 4-requester instance, 1-cycle memory
    for (int i = 0; i < 4; i++) b.req_addr_i[i*64 +: 64] = 64'(i * 16);
    b.req_read_i = 4'hF;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      @(negedge clk);
      chk("rr_grant", 64'(b.grant_o),  64'(exp_g));
      chk("rr_read",  64'(b.mem_read), 64'd1);
      chk("rr_addr",  b.mem_addr,      64'((k % 4) * 16));
      b.mem_resp = 1'b1;
      #1;
      chk("rr_resp", 64'(b.req_resp_o), 64'(exp_g));
      @(negedge clk);
      b.mem_resp = 1'b0;
      chk("rr_gap", 64'({b.mem_read, b.busy_o, b.grant_o}), 64'd0);
    end
    b.req_read_i = '0;

    // reset while a write is outstanding
    @(negedge clk);
    a.req_write_i[1]        = 1'b1;
    a.req_addr_i[64 +: 64]  = 64'h300;
    a.req_wdata_i[64 +: 64] = 64'h33;
    @(negedge clk);
    chk("midop_write", 64'(a.mem_write), 64'd1);
    chk("midop_grant", 64'(a.grant_o),   64'h2);
    #2;
    rst_n = 1'b0;
    a.req_read_i[0]       = 1'b1;
    a.req_addr_i[0 +: 64] = 64'h500;
    #1;
    chk("midop_rst_write", 64'(a.mem_write), 64'd0);
    chk("midop_rst_grant", 64'({a.grant_o, a.busy_o}), 64'd0);
    chk("midop_rst_resp",  64'(a.req_resp_o), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    txn_a(0, 1'b1, 1'b0, 64'h500, 64'h0,  64'h55, 1, 2'b01, 1'b1, 1'b0);
    txn_a(1, 1'b0, 1'b1, 64'h300, 64'h33, 64'h0,  1, 2'b10, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between NUM_REQ requesters, e.g. the random-access read and write stages of a pipeline.
- Sits between the requester modules and the memory model/cache.
- Uses round-robin arbitration with one outstanding transaction at a time.
- Latches the granted request, drives the memory command until mem_resp, then routes the response back to the owning requester.

Parameters:
- addr_width, 64, address width.
- data_width, 64, data width.
- NUM_REQ, 2, number of requesters; legal range 2..8.

Ports:
- clk  input  1  clock; all state updates on posedge.
- rst  input  1  asynchronous active-low reset; state clears immediately when low.
- req_read_i  input  NUM_REQ  per-requester read request.
- req_write_i  input  NUM_REQ  per-requester write request.
- req_addr_i  input  NUM_REQ*addr_width  packed addresses; requester i occupies bits [i*addr_width +: addr_width].
- req_wdata_i  input  NUM_REQ*data_width  packed write data; same packing as req_addr_i.
- req_resp_o  output  NUM_REQ  one-cycle completion pulse to the owning requester.
- req_rdata_o  output  data_width  read data, broadcast to all requesters; valid when req_resp_o[i]=1.
- mem_read  output  1  memory read command.
- mem_write  output  1  memory write command.
- mem_addr  output  addr_width  memory address.
- mem_wdata  output  data_width  memory write data.
- mem_resp  input  1  memory completion.
- mem_rdata  input  data_width  memory read data.
- grant_o  output  NUM_REQ  one-hot current owner; 0 when idle.
- busy_o  output  1  transaction outstanding.

Behaviour:
- Reset (rst=0, asynchronous):
  - state=IDLE.
  - grant_o=0, busy_o=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
  - Round-robin pointer last=NUM_REQ-1, so requester 0 has first priority.
  - Reset mid-transaction abandons it; no req_resp_o pulse is issued.
- Requester contract:
  - A requester holds its request and operands stable until it sees req_resp_o.
  - A request present in IDLE is valid if req_read_i[i] | req_write_i[i].
- IDLE state:
  - Sample valid requests each cycle.
  - If any are valid, pick the first valid index searching last+1, last+2, ... modulo NUM_REQ.
  - On the next edge: state=BUSY, grant_o=onehot(winner), last=winner, busy_o=1.
  - Also on that edge, register mem_addr/mem_wdata from the winner's slice.
  - Register mem_write=req_write_i[winner], and mem_read=req_read_i[winner] & ~req_write_i[winner]; write wins when both are set.
  - Command latency: a request sampled at edge t is visible on the mem_* outputs after edge t.
- BUSY state:
  - mem_* outputs are held constant; inputs are ignored.
  - A requester deasserting or changing its request mid-transaction has no effect.
  - When mem_resp=1: req_resp_o[granted] = 1 combinationally in the same cycle, and req_rdata_o = mem_rdata (req_rdata_o is a combinational pass-through of mem_rdata at all times).
  - On that edge: state=IDLE, mem_read=0, mem_write=0, grant_o=0, busy_o=0.
  - mem_addr/mem_wdata keep their last values.
- req_resp_o is 0 whenever state=IDLE or mem_resp=0.
- mem_resp while IDLE is ignored: no pulse, no state change.
- Back-to-back throughput:
  - The cycle after completion is always IDLE, so mem_read/mem_write are guaranteed low for at least 1 cycle between transactions.
  - Maximum rate is 1 transaction per (memory latency + 1) cycles.
- Fairness: with all requesters continuously requesting, grants rotate 0,1,..,NUM_REQ-1,0,... Each requester is starved for at most NUM_REQ-1 transactions.
- A single requester requesting continuously is granted back-to-back, separated only by the idle cycle.
- The pointer advances only on a grant, never on idle cycles.

Test Plan:
- Reset then idle: hold rst=0 for 3 cycles, release, no requests -> all outputs 0 for 10 cycles; mem_resp pulse while idle yields no req_resp_o.
- Single write: req1 write, addr=0x40, wdata=0xDEAD; memory responds 3 cycles after command -> mem_write=1 with addr 0x40/data 0xDEAD for exactly 3 cycles; req_resp_o=2'b10 in the mem_resp cycle; mem_write=0 the next cycle.
- Single read: req0 read addr=0x80; mem_rdata=0x1234 with mem_resp -> req_resp_o=2'b01 and req_rdata_o=0x1234 in the same cycle.
- Round robin: NUM_REQ=4, all four request continuously, 1-cycle memory -> grant_o sequence 0001,0010,0100,1000,0001; exactly 1 idle cycle between commands.
- Contention after reset: req0 and req1 both assert in the same cycle -> req0 is granted first, then req1. Requester with both read and write set -> mem_write=1, mem_read=0.
- Reset mid-op: assert rst=0 while BUSY with mem_write=1 -> mem_write=0 and grant_o=0 immediately (before the next clock edge). After release, a pending request is re-arbitrated from requester 0.
